// File: rtl/vin_ps2_keys.sv
// PS/2 scancode word to key-level bitmap: CDC sync, stability filter, make/break/E0 decode.
// Optional VIN_PS2_KEYS_ERRCLR_EN: BAT/error bytes (AA, 00, FF) clear all keys silently.
module vin_ps2_keys #(
  parameter int unsigned       KEYS      = 8,
  parameter int unsigned       STABLE    = 16,
  parameter logic [KEYS*9-1:0] KEY_CODES = {9'h014, 9'h012, 9'h17A, 9'h17D,
                                            9'h174, 9'h16B, 9'h172, 9'h175}
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [15:0]     code_i,
  output logic [KEYS-1:0] keys_o,
  output logic            event_o,
  output logic [8:0]      event_code_o,
  output logic            event_break_o
);

  localparam logic [7:0] StableCnt = 8'(STABLE);

  logic [15:0]     sync_q, code_s_q, cand_q, acc_q;
  logic [15:0]     cand_d, acc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            new_q, new_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [KEYS-1:0] keys_q, keys_d;
  logic            event_q, event_d;
  logic [8:0]      event_code_q, event_code_d;
  logic            event_break_q, event_break_d;

  logic [7:0] b;
  logic [8:0] key_code;
  logic       is_err;

  assign b        = acc_q[7:0];
  assign key_code = {ext_q, b};

`ifdef VIN_PS2_KEYS_ERRCLR_EN
  assign is_err = (b == 8'hAA) || (b == 8'h00) || (b == 8'hFF);
`else
  assign is_err = 1'b0;
`endif

  // Accept fires on the same edge the count reaches STABLE, so a word needs STABLE quiet cycles.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    new_d  = 1'b0;
    if (code_s_q != cand_q) begin
      cand_d = code_s_q;
      cnt_d  = '0;
    end else if (cnt_q < StableCnt) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == StableCnt && cand_q != acc_q) begin
        acc_d = cand_q;
        new_d = 1'b1;
      end
    end
  end

  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    keys_d        = keys_q;
    event_d       = 1'b0;
    event_code_d  = event_code_q;
    event_break_d = event_break_q;
    if (new_q) begin
      if (b == 8'hE0) begin
        ext_d = 1'b1;
      end else if (b == 8'hF0) begin
        brk_d = 1'b1;
      end else if (is_err) begin
        keys_d = '0;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else begin
        event_d       = 1'b1;
        event_code_d  = key_code;
        event_break_d = brk_q;
        ext_d         = 1'b0;
        brk_d         = 1'b0;
        for (int unsigned i = 0; i < KEYS; i++) begin
          if (KEY_CODES[9*i +: 9] == key_code) keys_d[i] = ~brk_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q        <= '0;
      code_s_q      <= '0;
      cand_q        <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      new_q         <= 1'b0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      keys_q        <= '0;
      event_q       <= 1'b0;
      event_code_q  <= '0;
      event_break_q <= 1'b0;
    end else begin
      sync_q        <= code_i;
      code_s_q      <= sync_q;
      cand_q        <= cand_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      new_q         <= new_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      keys_q        <= keys_d;
      event_q       <= event_d;
      event_code_q  <= event_code_d;
      event_break_q <= event_break_d;
    end
  end

  assign keys_o        = keys_q;
  assign event_o       = event_q;
  assign event_code_o  = event_code_q;
  assign event_break_o = event_break_q;

endmodule

// File: tb/tb_vin_ps2_keys.sv
// Directed bench for vin_ps2_keys: vector table of code words plus latency/glitch/reset sequences.
module tb_vin_ps2_keys;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] code = 16'h0000;
  logic [7:0]  keys;
  logic        ev;
  logic [8:0]  ev_code;
  logic        ev_brk;

  int checks = 0;
  int failures = 0;
  int ev_total = 0;

  vin_ps2_keys dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .code_i       (code),
    .keys_o       (keys),
    .event_o      (ev),
    .event_code_o (ev_code),
    .event_break_o(ev_brk)
  );

  always #5 clk = ~clk;

  // Count strobes on the falling edge; a stretched pulse would count twice.
  always @(negedge clk) if (ev) ev_total <= ev_total + 1;

  typedef struct {
    logic [15:0] code;
    int          n_ev;
    logic [8:0]  ev_code;
    logic        ev_brk;
    logic [7:0]  keys;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] c, input int cycles);
    @(posedge clk);
    #1 code = c;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int ev0;
    int lat;
    logic [7:0] err_keys;

    tbl[0]  = '{16'h0075, 1, 9'h075, 1'b0, 8'h00};
    tbl[1]  = '{16'h75E0, 0, 9'h075, 1'b0, 8'h00};
    tbl[2]  = '{16'hE075, 1, 9'h175, 1'b0, 8'h01};
    tbl[3]  = '{16'h75E0, 0, 9'h175, 1'b0, 8'h01};
    tbl[4]  = '{16'hE0F0, 0, 9'h175, 1'b0, 8'h01};
    tbl[5]  = '{16'hF075, 1, 9'h175, 1'b1, 8'h00};
    tbl[6]  = '{16'h7512, 1, 9'h012, 1'b0, 8'h40};
    tbl[7]  = '{16'h1214, 1, 9'h014, 1'b0, 8'hC0};
    tbl[8]  = '{16'h14F0, 0, 9'h014, 1'b0, 8'hC0};
    tbl[9]  = '{16'hF012, 1, 9'h012, 1'b1, 8'h80};
    tbl[10] = '{16'h1212, 1, 9'h012, 1'b0, 8'hC0};
    tbl[11] = '{16'h12F0, 0, 9'h012, 1'b0, 8'hC0};
    tbl[12] = '{16'hF014, 1, 9'h014, 1'b1, 8'h40};
    tbl[13] = '{16'h1414, 1, 9'h014, 1'b0, 8'hC0};
`ifdef VIN_PS2_KEYS_ERRCLR_EN
    tbl[14] = '{16'h14AA, 0, 9'h014, 1'b0, 8'h00};
    err_keys = 8'h00;
`else
    tbl[14] = '{16'h14AA, 1, 9'h0AA, 1'b0, 8'hC0};
    err_keys = 8'hC0;
`endif
    tbl[15] = '{16'hAAE0, 0, tbl[14].ev_code, 1'b0, err_keys};
    tbl[16] = '{16'hE0F0, 0, tbl[14].ev_code, 1'b0, err_keys};
    // Extended break of Left, which is not held: bit stays 0.
    tbl[17] = '{16'hF06B, 1, 9'h16B, 1'b1, err_keys};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_keys", 32'(keys), 32'h0);
    chk("reset_event", 32'(ev), 32'h0);
    chk("reset_event_code", 32'(ev_code), 32'h0);
    chk("reset_event_break", 32'(ev_brk), 32'h0);
    reset = 1'b0;

    for (int r = 0; r < 18; r++) begin
      ev0 = ev_total;
      drive(tbl[r].code, 40);
      chk($sformatf("row%0d_events", r), 32'(ev_total - ev0), 32'(tbl[r].n_ev));
      chk($sformatf("row%0d_keys", r), 32'(keys), 32'(tbl[r].keys));
      if (tbl[r].n_ev != 0) begin
        chk($sformatf("row%0d_event_code", r), 32'(ev_code), 32'(tbl[r].ev_code));
        chk($sformatf("row%0d_event_break", r), 32'(ev_brk), 32'(tbl[r].ev_brk));
      end
    end

    // Reset after an E0 prefix must drop the pending extended flag.
    ev0 = ev_total;
    drive(16'h00E0, 40);
    chk("prefix_no_event", 32'(ev_total - ev0), 32'h0);
    reset = 1'b1;
    code  = 16'h0000;
    #2;
    chk("midreset_keys", 32'(keys), 32'h0);
    chk("midreset_event_code", 32'(ev_code), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    ev0 = ev_total;
    lat = 0;
    @(posedge clk);
    #1 code = 16'h0075;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (ev) begin
        lat = k;
        break;
      end
    end
    chk("latency_cycles", 32'(lat), 32'd20);
    repeat (20) @(posedge clk);
    #1;
    chk("after_reset_events", 32'(ev_total - ev0), 32'h1);
    chk("after_reset_code", 32'(ev_code), 32'h075);

    // Short glitch on an already accepted word: nothing happens.
    ev0 = ev_total;
    drive(16'hFFFF, 3);
    drive(16'h0075, 40);
    chk("glitch_idle_events", 32'(ev_total - ev0), 32'h0);

    // Glitch during filtering of a new word: still exactly one event.
    ev0 = ev_total;
    drive(16'h0012, 5);
    drive(16'hFFFF, 3);
    drive(16'h0012, 40);
    chk("glitch_events", 32'(ev_total - ev0), 32'h1);
    chk("glitch_code", 32'(ev_code), 32'h012);
    chk("glitch_keys", 32'(keys), 32'h40);

    // Typematic repeat: 12 12 then held is one more event, held word adds none.
    ev0 = ev_total;
    drive(16'h1212, 40);
    chk("typematic_events", 32'(ev_total - ev0), 32'h1);
    ev0 = ev_total;
    repeat (40) @(posedge clk);
    #1;
    chk("typematic_hold_events", 32'(ev_total - ev0), 32'h0);
    chk("typematic_keys", 32'(keys), 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
